dcfir_vmm_param: RTL and testbench

DCFIR_VMM_PARAM -- requirements
Module: dcfir_vmm_param

---
 rtl/dcfir_vmm_param_if.sv | 38 +++
 rtl/dcfir_vmm_param.sv | 244 ++++++++++++++++++++++++
 tb/tb_dcfir_vmm_param.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dcfir_vmm_param_if.sv
// Sample, coefficient-load and result signals of the windowed complex FIR.
// The master side feeds samples and coefficients; the slave side is the filter.
interface dcfir_vmm_param_if #(
    parameter int DW    = 16,
    parameter int CW    = 10,
    parameter int DEPTH = 32,
    parameter int NTAP  = 4,
    parameter int OW    = 16
);
    localparam int SW = $clog2(DEPTH);
    localparam int TW = $clog2(NTAP);

    logic                 in_valid;
    logic signed [DW-1:0] din_real;
    logic signed [DW-1:0] din_imag;
    logic [SW-1:0]        sel;
    logic                 coe_wr_en;
    logic [TW-1:0]        coe_wr_addr;
    logic signed [CW-1:0] coe_wr_real;
    logic signed [CW-1:0] coe_wr_imag;
    logic                 coe_commit;
    logic                 out_valid;
    logic signed [OW-1:0] out_real;
    logic signed [OW-1:0] out_imag;
    logic                 sat_flag;

    modport master (
        output in_valid, din_real, din_imag, sel,
        output coe_wr_en, coe_wr_addr, coe_wr_real, coe_wr_imag, coe_commit,
        input  out_valid, out_real, out_imag, sat_flag
    );

    modport slave (
        input  in_valid, din_real, din_imag, sel,
        input  coe_wr_en, coe_wr_addr, coe_wr_real, coe_wr_imag, coe_commit,
        output out_valid, out_real, out_imag, sat_flag
    );
endinterface

// File: rtl/dcfir_vmm_param.sv
// Complex FIR over a selectable window of a sample delay line, with double-buffered
// coefficients, full-precision accumulation and round/saturate output.
module dcfir_vmm_param #(
    parameter int DW    = 16,
    parameter int CW    = 10,
    parameter int DEPTH = 32,
    parameter int NTAP  = 4,
    parameter int OW    = 16,
    parameter int SHIFT = 8
) (
    input logic              CLK,
    input logic              rst_n,
    dcfir_vmm_param_if.slave bus
);
    localparam int SW = $clog2(DEPTH);
    localparam int TW = $clog2(NTAP);
    localparam int PW = DW + CW + 1;
    localparam int AW = PW + TW;
    localparam int FW = SW + 1;

    localparam logic [SW-1:0] SEL_MAX  = SW'(DEPTH - NTAP);
    localparam logic [FW-1:0] FILL_MAX = FW'(DEPTH);

    localparam logic signed [AW:0] RND  = {{AW{1'b0}}, 1'b1} << (SHIFT - 1);
    localparam logic signed [AW:0] OMAX = {{(AW + 2 - OW){1'b0}}, {(OW - 1){1'b1}}};
    localparam logic signed [AW:0] OMIN = {{(AW + 2 - OW){1'b1}}, {(OW - 1){1'b0}}};

    // Round half up, then arithmetic shift; one guard bit keeps the add exact.
    function automatic logic signed [AW:0] rnd_shift(input logic signed [AW-1:0] a);
        logic signed [AW:0] t;
        t = $signed({a[AW-1], a}) + RND;
        return t >>> SHIFT;
    endfunction

    // Returns {clipped, value} with value clamped to the signed OW range.
    function automatic logic [OW:0] sat_rail(input logic signed [AW:0] v);
        if (v > OMAX) begin
            return {1'b1, 1'b0, {(OW - 1){1'b1}}};
        end else if (v < OMIN) begin
            return {1'b1, 1'b1, {(OW - 1){1'b0}}};
        end else begin
            return {1'b0, v[OW-1:0]};
        end
    endfunction

    logic signed [DW-1:0] dly_real [DEPTH];
    logic signed [DW-1:0] dly_imag [DEPTH];
    logic [FW-1:0]        fill_cnt;
    logic [FW-1:0]        fill_nxt;
    logic [SW-1:0]        sel_c;
    logic                 warm;
    logic [SW-1:0]        sel_p0;
    logic                 vld_p0;

    logic signed [CW-1:0] shd_real [NTAP];
    logic signed [CW-1:0] shd_imag [NTAP];
    logic signed [CW-1:0] act_real [NTAP];
    logic signed [CW-1:0] act_imag [NTAP];
    logic [NTAP-1:0]      wr_hit;

    logic signed [DW-1:0] xr_p1 [NTAP];
    logic signed [DW-1:0] xi_p1 [NTAP];
    logic signed [CW-1:0] cr_p1 [NTAP];
    logic signed [CW-1:0] ci_p1 [NTAP];
    logic                 vld_p1;

    logic signed [PW-1:0] pr_p2 [NTAP];
    logic signed [PW-1:0] pi_p2 [NTAP];
    logic                 vld_p2;

    logic signed [AW-1:0] acc_r_p3;
    logic signed [AW-1:0] acc_i_p3;
    logic                 vld_p3;

    logic signed [AW:0]   shr_r;
    logic signed [AW:0]   shr_i;
    logic [OW:0]          sat_r;
    logic [OW:0]          sat_i;
    logic signed [OW-1:0] out_r_p4;
    logic signed [OW-1:0] out_i_p4;
    logic                 sat_p4;
    logic                 vld_p4;

    always_comb begin
        sel_c    = (bus.sel > SEL_MAX) ? SEL_MAX : bus.sel;
        fill_nxt = (fill_cnt == FILL_MAX) ? FILL_MAX : fill_cnt + 1'b1;
        warm     = fill_nxt >= ({1'b0, sel_c} + FW'(NTAP));
    end

    // Stage p0: accept sample into the delay line, latch clamped window start.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                dly_real[i] <= '0;
                dly_imag[i] <= '0;
            end
            fill_cnt <= '0;
            sel_p0   <= '0;
            vld_p0   <= 1'b0;
        end else begin
            vld_p0 <= bus.in_valid && warm;
            if (bus.in_valid) begin
                dly_real[0] <= bus.din_real;
                dly_imag[0] <= bus.din_imag;
                for (int i = 1; i < DEPTH; i++) begin
                    dly_real[i] <= dly_real[i-1];
                    dly_imag[i] <= dly_imag[i-1];
                end
                fill_cnt <= fill_nxt;
                sel_p0   <= sel_c;
            end
        end
    end

    always_comb begin
        wr_hit = '0;
        for (int k = 0; k < NTAP; k++) begin
            wr_hit[k] = bus.coe_wr_en && (bus.coe_wr_addr == TW'(k));
        end
    end

    // A commit forwards a same-cycle write so the whole set lands at once.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NTAP; k++) begin
                shd_real[k] <= '0;
                shd_imag[k] <= '0;
                act_real[k] <= '0;
                act_imag[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NTAP; k++) begin
                if (wr_hit[k]) begin
                    shd_real[k] <= bus.coe_wr_real;
                    shd_imag[k] <= bus.coe_wr_imag;
                end
                if (bus.coe_commit) begin
                    act_real[k] <= wr_hit[k] ? bus.coe_wr_real : shd_real[k];
                    act_imag[k] <= wr_hit[k] ? bus.coe_wr_imag : shd_imag[k];
                end
            end
        end
    end

    // Stage p1: window and coefficient capture.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NTAP; k++) begin
                xr_p1[k] <= '0;
                xi_p1[k] <= '0;
                cr_p1[k] <= '0;
                ci_p1[k] <= '0;
            end
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= vld_p0;
            if (vld_p0) begin
                for (int k = 0; k < NTAP; k++) begin
                    xr_p1[k] <= dly_real[sel_p0 + SW'(k)];
                    xi_p1[k] <= dly_imag[sel_p0 + SW'(k)];
                    cr_p1[k] <= act_real[k];
                    ci_p1[k] <= act_imag[k];
                end
            end
        end
    end

    // Stage p2: per-tap complex products.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NTAP; k++) begin
                pr_p2[k] <= '0;
                pi_p2[k] <= '0;
            end
            vld_p2 <= 1'b0;
        end else begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                for (int k = 0; k < NTAP; k++) begin
                    pr_p2[k] <= PW'(xr_p1[k]) * PW'(cr_p1[k]) - PW'(xi_p1[k]) * PW'(ci_p1[k]);
                    pi_p2[k] <= PW'(xr_p1[k]) * PW'(ci_p1[k]) + PW'(xi_p1[k]) * PW'(cr_p1[k]);
                end
            end
        end
    end

    for (genvar l = 0; l <= TW; l++) begin : g_lvl
        logic signed [AW-1:0] nr [NTAP >> l];
        logic signed [AW-1:0] ni [NTAP >> l];
        for (genvar k = 0; k < (NTAP >> l); k++) begin : g_node
            if (l == 0) begin : g_leaf
                assign nr[k] = AW'(pr_p2[k]);
                assign ni[k] = AW'(pi_p2[k]);
            end else begin : g_sum
                assign nr[k] = g_lvl[l-1].nr[2*k] + g_lvl[l-1].nr[2*k+1];
                assign ni[k] = g_lvl[l-1].ni[2*k] + g_lvl[l-1].ni[2*k+1];
            end
        end
    end

    // Stage p3: adder tree result.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            acc_r_p3 <= '0;
            acc_i_p3 <= '0;
            vld_p3   <= 1'b0;
        end else begin
            vld_p3 <= vld_p2;
            if (vld_p2) begin
                acc_r_p3 <= g_lvl[TW].nr[0];
                acc_i_p3 <= g_lvl[TW].ni[0];
            end
        end
    end

    always_comb begin
        shr_r = rnd_shift(acc_r_p3);
        shr_i = rnd_shift(acc_i_p3);
        sat_r = sat_rail(shr_r);
        sat_i = sat_rail(shr_i);
    end

    // Stage p4: rounded, saturated outputs; held between results.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            out_r_p4 <= '0;
            out_i_p4 <= '0;
            sat_p4   <= 1'b0;
            vld_p4   <= 1'b0;
        end else begin
            vld_p4 <= vld_p3;
            if (vld_p3) begin
                out_r_p4 <= sat_r[OW-1:0];
                out_i_p4 <= sat_i[OW-1:0];
                sat_p4   <= sat_r[OW] | sat_i[OW];
            end
        end
    end

    assign bus.out_valid = vld_p4;
    assign bus.out_real  = out_r_p4;
    assign bus.out_imag  = out_i_p4;
    assign bus.sat_flag  = sat_p4;
endmodule

// File: tb/tb_dcfir_vmm_param.sv
// Directed bench for dcfir_vmm_param: warm-up/clamp, impulse, rotation, rounding,
// saturation, coefficient double-buffering and mid-stream reset.
module tb_dcfir_vmm_param;
    localparam int DW    = 16;
    localparam int CW    = 10;
    localparam int DEPTH = 32;
    localparam int NTAP  = 4;
    localparam int OW    = 16;
    localparam int SHIFT = 8;
    localparam int SW    = $clog2(DEPTH);
    localparam int TW    = $clog2(NTAP);

    logic CLK   = 1'b0;
    logic rst_n = 1'b1;
    int   n_vec  = 0;
    int   n_miss = 0;

    dcfir_vmm_param_if #(.DW(DW), .CW(CW), .DEPTH(DEPTH), .NTAP(NTAP), .OW(OW)) bus ();

    dcfir_vmm_param #(
        .DW(DW), .CW(CW), .DEPTH(DEPTH), .NTAP(NTAP), .OW(OW), .SHIFT(SHIFT)
    ) dut (
        .CLK  (CLK),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_bus();
        bus.in_valid    = 1'b0;
        bus.din_real    = '0;
        bus.din_imag    = '0;
        bus.sel         = '0;
        bus.coe_wr_en   = 1'b0;
        bus.coe_wr_addr = '0;
        bus.coe_wr_real = '0;
        bus.coe_wr_imag = '0;
        bus.coe_commit  = 1'b0;
    endtask

    task automatic set_coef(input int addr, input int cr, input int ci);
        bus.coe_wr_en   = 1'b1;
        bus.coe_wr_addr = TW'(addr);
        bus.coe_wr_real = CW'(cr);
        bus.coe_wr_imag = CW'(ci);
        tick();
        bus.coe_wr_en   = 1'b0;
    endtask

    task automatic commit();
        bus.coe_commit = 1'b1;
        tick();
        bus.coe_commit = 1'b0;
    endtask

    // cnt back-to-back samples, then wait until the last one's result is visible.
    task automatic burst(input int s, input int r, input int i, input int cnt);
        for (int c = 0; c < cnt; c++) begin
            bus.in_valid = 1'b1;
            bus.sel      = SW'(s);
            bus.din_real = DW'(r);
            bus.din_imag = DW'(i);
            tick();
            bus.coe_wr_en  = 1'b0;
            bus.coe_commit = 1'b0;
        end
        bus.in_valid = 1'b0;
        bus.sel      = ~SW'(s);
        repeat (4) tick();
    endtask

    // Samples j*rstep / j*istep for j=1..n; counts any out_valid before the last result.
    task automatic stream(input int s, input int n, input int rstep, input int istep,
                          output int early);
        early = 0;
        for (int j = 1; j <= n; j++) begin
            bus.in_valid = 1'b1;
            bus.sel      = SW'(s);
            bus.din_real = DW'(j * rstep);
            bus.din_imag = DW'(j * istep);
            tick();
            if (bus.out_valid) early++;
        end
        bus.in_valid = 1'b0;
        repeat (3) begin
            tick();
            if (bus.out_valid) early++;
        end
        tick();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int early;
        idle_bus();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_real",  bus.out_real,  0);
        chk("rst_imag",  bus.out_imag,  0);
        chk("rst_sat",   bus.sat_flag,  0);
        repeat (2) @(posedge CLK);
        #3 rst_n = 1'b1;
        tick();

        // sel=31 clamps to 28; first result only on sample 32, taps on stages 28..31
        set_coef(0, 256, 0);
        set_coef(1, 128, 0);
        set_coef(2, 64, 0);
        set_coef(3, 32, 0);
        commit();
        stream(31, DEPTH, 100, -10, early);
        chk("warm_early_valid", early, 0);
        chk("warm_valid", bus.out_valid, 1);
        chk("warm_real", bus.out_real, 613);
        chk("warm_imag", bus.out_imag, -61);

        // impulse with in_valid held high
        set_coef(0, 256, 0);
        set_coef(1, 0, 0);
        set_coef(2, 0, 0);
        set_coef(3, 0, 0);
        commit();
        bus.sel      = '0;
        bus.in_valid = 1'b1;
        bus.din_real = DW'(1000);
        bus.din_imag = '0;
        tick();
        bus.din_real = '0;
        repeat (4) tick();
        chk("imp_valid", bus.out_valid, 1);
        chk("imp_real", bus.out_real, 1000);
        chk("imp_imag", bus.out_imag, 0);
        tick();
        chk("imp_tail_valid", bus.out_valid, 1);
        chk("imp_tail_real", bus.out_real, 0);
        bus.in_valid = 1'b0;

        // rotation by j; sel wiggles after the sample is taken
        set_coef(0, 0, 256);
        commit();
        burst(0, 300, -200, 1);
        chk("rot_real", bus.out_real, 200);
        chk("rot_imag", bus.out_imag, 300);
        chk("rot_sat", bus.sat_flag, 0);
        tick();
        chk("hold_valid", bus.out_valid, 0);
        chk("hold_real", bus.out_real, 200);

        // rounding at the half-LSB points
        set_coef(0, 1, 0);
        commit();
        burst(0, 128, 0, 1);
        chk("rnd_p128", bus.out_real, 1);
        burst(0, 127, 0, 1);
        chk("rnd_p127", bus.out_real, 0);
        burst(0, -129, 0, 1);
        chk("rnd_m129", bus.out_real, -1);
        burst(0, -128, 0, 1);
        chk("rnd_m128", bus.out_real, 0);

        // saturation on both rails and on the imag path alone
        for (int k = 0; k < NTAP; k++) set_coef(k, 255, 0);
        commit();
        burst(0, 32767, 0, 4);
        chk("sat_pos_real", bus.out_real, 32767);
        chk("sat_pos_flag", bus.sat_flag, 1);
        burst(0, -32768, 0, 4);
        chk("sat_neg_real", bus.out_real, -32768);
        chk("sat_neg_flag", bus.sat_flag, 1);
        burst(0, 0, 32767, 4);
        chk("sat_im_real", bus.out_real, 0);
        chk("sat_im_imag", bus.out_imag, 32767);
        chk("sat_im_flag", bus.sat_flag, 1);

        // full-scale at unity gain does not clip
        set_coef(0, 256, 0);
        set_coef(1, 0, 0);
        set_coef(2, 0, 0);
        set_coef(3, 0, 0);
        commit();
        burst(0, 32767, 0, 1);
        chk("edge_pos_real", bus.out_real, 32767);
        chk("edge_pos_flag", bus.sat_flag, 0);
        burst(0, -32768, 0, 1);
        chk("edge_neg_real", bus.out_real, -32768);
        chk("edge_neg_flag", bus.sat_flag, 0);

        // shadow writes stay invisible until commit; commit sample sees whole new set
        bus.coe_wr_en   = 1'b1;
        bus.coe_wr_addr = TW'(0);
        bus.coe_wr_real = CW'(128);
        bus.coe_wr_imag = '0;
        burst(0, 1000, 0, 1);
        chk("dbuf_old_a", bus.out_real, 1000);
        set_coef(2, 64, 0);
        burst(0, 1000, 0, 1);
        chk("dbuf_old_b", bus.out_real, 1000);
        bus.coe_commit  = 1'b1;
        bus.coe_wr_en   = 1'b1;
        bus.coe_wr_addr = TW'(1);
        bus.coe_wr_real = CW'(256);
        bus.coe_wr_imag = '0;
        burst(0, 1000, 0, 1);
        chk("dbuf_new", bus.out_real, 1750);

        // reset with three samples in flight
        bus.in_valid = 1'b1;
        bus.sel      = '0;
        bus.din_real = DW'(1000);
        bus.din_imag = '0;
        repeat (3) tick();
        bus.in_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("mrst_real", bus.out_real, 0);
        chk("mrst_imag", bus.out_imag, 0);
        chk("mrst_valid", bus.out_valid, 0);
        chk("mrst_sat", bus.sat_flag, 0);
        @(posedge CLK);
        #3 rst_n = 1'b1;
        early = 0;
        repeat (8) begin
            tick();
            if (bus.out_valid) early++;
        end
        chk("mrst_no_valid", early, 0);

        // warm-up restarts from an empty fill count
        set_coef(0, 256, 0);
        commit();
        stream(0, NTAP, 10, 0, early);
        chk("restart_early", early, 0);
        chk("restart_valid", bus.out_valid, 1);
        chk("restart_real", bus.out_real, 40);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
